// File: rtl/encoder_pkg.sv
// Shared line-code constants and state encoding for the pulse-interval encoder.
package encoder_pkg;

  localparam int PACKET_SIZE            = 8;
  localparam int COUNTER_SIZE           = 4;
  localparam int INTERVAL_LOW           = 2;
  localparam int INTERVAL_HIGH          = 5;
  localparam int GUARD_INTERVAL_DEFAULT = INTERVAL_HIGH;

  // Bit index width; a 1-bit word still needs a 1-bit index register.
  localparam int IDX_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_START,
    ENC_GAP,
    ENC_PULSE,
    ENC_GUARD
  } enc_state_e;

  // Timer load value for a bit's gap: the timer counts load..0, so N low
  // cycles need a load of N-1.
  function automatic logic [COUNTER_SIZE-1:0] gap_load(input logic b);
    return b ? COUNTER_SIZE'(INTERVAL_HIGH - 1) : COUNTER_SIZE'(INTERVAL_LOW - 1);
  endfunction

endpackage

// File: rtl/encoder_interval_timer.sv
// Loadable down-counter shared by the GAP and GUARD phases; saturates at 0.
module encoder_interval_timer
  import encoder_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] value,
  output logic                    zero
);

  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;

  // Load wins over counting; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = value;
    else if (cnt_q != '0)
      cnt_d = cnt_q - COUNTER_SIZE'(1);
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/encoder.sv
// Pulse-interval line encoder: start pulse, then one pulse per data bit (LSB
// first) whose preceding low-time encodes the bit value.
module encoder
  import encoder_pkg::*;
#(
  parameter int GUARD_INTERVAL = GUARD_INTERVAL_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   signal,
  output logic                   done
);

  // Parameter sanity: the receiver needs distinguishable gaps and the timer
  // must be able to hold every load value.
  if (INTERVAL_LOW < 2) begin : g_bad_low
    $error("encoder: INTERVAL_LOW must be >= 2");
  end
  if (INTERVAL_HIGH < INTERVAL_LOW + 2) begin : g_bad_high
    $error("encoder: INTERVAL_HIGH must be >= INTERVAL_LOW + 2");
  end
  if (INTERVAL_HIGH >= 2**COUNTER_SIZE || GUARD_INTERVAL >= 2**COUNTER_SIZE
      || GUARD_INTERVAL < 1) begin : g_bad_cnt
    $error("encoder: intervals must fit the interval timer");
  end

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(PACKET_SIZE - 1);
  localparam logic [COUNTER_SIZE-1:0] GUARD_LOAD = COUNTER_SIZE'(GUARD_INTERVAL - 1);

  enc_state_e             state_q, state_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   signal_q, signal_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic                    tmr_load;
  logic [COUNTER_SIZE-1:0] tmr_value;
  logic                    tmr_zero;
  logic [PACKET_SIZE-1:0]  shifted;

  encoder_interval_timer u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Next-state and registered-output logic. signal/done default low so every
  // pulse is exactly one cycle wide.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    signal_d  = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    shifted   = shreg_q >> 1;
    unique case (state_q)
      ENC_IDLE: begin
        if (data_valid && ready_q) begin
          shreg_d  = data;
          ready_d  = 1'b0;
          signal_d = 1'b1;
          state_d  = ENC_START;
        end
      end
      ENC_START: begin
        tmr_load  = 1'b1;
        tmr_value = gap_load(shreg_q[0]);
        state_d   = ENC_GAP;
      end
      ENC_GAP: begin
        if (tmr_zero) begin
          signal_d = 1'b1;
          // done rides along with the final pulse
          done_d   = (idx_q == LAST_IDX);
          state_d  = ENC_PULSE;
        end
      end
      ENC_PULSE: begin
        shreg_d  = shifted;
        tmr_load = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          tmr_value = GUARD_LOAD;
          state_d   = ENC_GUARD;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          tmr_value = gap_load(shifted[0]);
          state_d   = ENC_GAP;
        end
      end
      ENC_GUARD: begin
        if (tmr_zero) begin
          ready_d = 1'b1;
          state_d = ENC_IDLE;
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ENC_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      signal_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      signal_q <= signal_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign signal     = signal_q;
  assign done       = done_q;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder with a receiver model decoding the signal line.
module tb_encoder;
  import encoder_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, signal, done;

  encoder #(.GUARD_INTERVAL(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .signal     (signal),
    .done       (done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Receiver model / line monitor, sampling pre-edge values at posedge.
  int         cyc = 0, lowcnt = 0, nbits = 0, gerr = 0, dbl = 0;
  int         done_n = 0, last_done = -1, rdy_rise = -1;
  bit         inpkt = 0, prev_sig = 0, prev_rdy = 1;
  logic [7:0] word = '0;
  int         pulse_q[$];
  logic [7:0] dec_q[$];

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    prev_sig <= (signal === 1'b1);
    prev_rdy <= (data_ready === 1'b1);
    if (signal === 1'b1 && prev_sig) dbl <= dbl + 1;
    if (done === 1'b1) begin done_n <= done_n + 1; last_done <= cyc; end
    if (data_ready === 1'b1 && !prev_rdy) rdy_rise <= cyc;
    if (reset) begin
      inpkt  <= 1'b0;
      lowcnt <= 0;
    end else if (signal === 1'b1) begin
      pulse_q.push_back(cyc);
      lowcnt <= 0;
      if (!inpkt) begin
        inpkt <= 1'b1;
        nbits <= 0;
        word  <= '0;
      end else begin
        if (lowcnt != INTERVAL_LOW && lowcnt != INTERVAL_HIGH) gerr <= gerr + 1;
        word  <= {lowcnt == INTERVAL_HIGH, word[7:1]};
        nbits <= nbits + 1;
        if (nbits == 7) begin
          dec_q.push_back({lowcnt == INTERVAL_HIGH, word[7:1]});
          inpkt <= 1'b0;
        end
      end
    end else begin
      lowcnt <= lowcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a word and wait (bounded) for the accepting edge.
  int acc_cyc = 0;
  task automatic send(input logic [7:0] w, input bit hold);
    bit acc = 0;
    @(negedge clock);
    data = w;
    data_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(posedge clock);
      if (data_ready === 1'b1) begin acc = 1; acc_cyc = cyc; end
    end
    check("accept", 32'(acc), 1);
    @(negedge clock);
    if (!hold) data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, dn0, hi, bad;
    int exp_off[9];
    logic [7:0] words[4];

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_signal", 32'(signal), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(data_ready), 1);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 1. 8'hA5: bits LSB first 1,0,1,0,0,1,0,1 -> gaps 5,2,5,2,2,5,2,5
    exp_off = '{0, 6, 9, 15, 18, 21, 27, 30, 36};
    p0 = pulse_q.size(); d0 = dec_q.size(); dn0 = done_n;
    send(8'hA5, 0);
    repeat (50) @(negedge clock);
    check("a5_npulses", 32'(pulse_q.size() - p0), 9);
    check("a5_latency", 32'(pulse_q[p0] - acc_cyc), 1);
    for (int i = 1; i < 9; i++)
      check($sformatf("a5_off%0d", i), 32'(pulse_q[p0+i] - pulse_q[p0]), 32'(exp_off[i]));
    check("a5_done_n", 32'(done_n - dn0), 1);
    check("a5_done_at", 32'(last_done), 32'(pulse_q[p0+8]));
    check("a5_ready_at", 32'(rdy_rise), 32'(pulse_q[p0+8] + 6));
    check("a5_decode", 32'(dec_q[d0]), 32'h A5);

    // 2. Loopback decode of several words
    words = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    d0 = dec_q.size(); dn0 = done_n;
    for (int i = 0; i < 4; i++) send(words[i], 0);
    repeat (60) @(negedge clock);
    check("lb_count", 32'(dec_q.size() - d0), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("lb_word%0d", i), 32'(dec_q[d0+i]), 32'(words[i]));
    check("lb_done_n", 32'(done_n - dn0), 4);

    // 3. Back-to-back with valid held: 6 low cycles between packets
    p0 = pulse_q.size(); d0 = dec_q.size();
    send(8'h01, 1);
    send(8'h80, 0);
    repeat (60) @(negedge clock);
    check("b2b_npulses", 32'(pulse_q.size() - p0), 18);
    check("b2b_spacing", 32'(pulse_q[p0+9] - pulse_q[p0+8]), 7);
    check("b2b_word0", 32'(dec_q[d0]), 32'h01);
    check("b2b_word1", 32'(dec_q[d0+1]), 32'h80);

    // 4. Valid pulsed mid-packet is ignored; 3C has four 1s and four 0s
    p0 = pulse_q.size(); d0 = dec_q.size();
    send(8'h3C, 0);
    repeat (10) @(negedge clock);
    data = 8'hFF; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (60) @(negedge clock);
    check("ign_npulses", 32'(pulse_q.size() - p0), 9);
    check("ign_duration", 32'(pulse_q[p0+8] - pulse_q[p0]), 36);
    check("ign_decode", 32'(dec_q[d0]), 32'h3C);
    check("ign_ndec", 32'(dec_q.size() - d0), 1);

    // 5. Reset during the 4th pulse of 8'hFF
    d0 = dec_q.size(); dn0 = done_n;
    send(8'hFF, 0);
    hi = 0;
    if (signal === 1'b1) hi++;
    for (int i = 0; i < 200 && hi < 4; i++) begin
      @(negedge clock);
      if (signal === 1'b1) hi++;
    end
    check("rst_mid_found", 32'(hi), 4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_signal", 32'(signal), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_ready", 32'(data_ready), 1);
    repeat (60) @(negedge clock);
    check("rst_mid_nodone", 32'(done_n - dn0), 0);
    check("rst_mid_nodec", 32'(dec_q.size() - d0), 0);
    send(8'h12, 0);
    repeat (50) @(negedge clock);
    check("rst_after_decode", 32'(dec_q[d0]), 32'h12);
    check("rst_after_done", 32'(done_n - dn0), 1);

    // 6. Idle with valid low
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (signal !== 1'b0 || done !== 1'b0 || data_ready !== 1'b1) bad++;
    end
    check("idle_quiet", 32'(bad), 0);

    // Line-code invariants across the whole run
    check("gap_lengths", 32'(gerr), 0);
    check("pulse_width", 32'(dbl), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
